ssd_scan_driver: RTL
====================

Name: ssd_scan_driver

Overview:
- Parametrised time-multiplexed seven-segment scan driver for N_DIGITS common-anode digits.
- Successor to the fixed 8-digit scanner. Adds the following:
  - correct wrap at any digit count
  - inter-digit dead time (anti-ghosting)
  - PWM brightness
  - per-digit blanking and decimal points
  - frame-coherent input snapshot
- Sits between counter/data logic and the board anode/cathode pins.

Parameters:
- N_DIGITS, 8: number of digits scanned; legal range 1..16.
- CLK_HZ, 100_000_000: clk frequency in Hz.
- REFRESH_HZ, 1000: full-frame refresh rate in Hz.
- DEAD_CYCLES, 100: cycles at the start of each slot with all anodes off.
- BRIGHT_W, 4: width of the brightness input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable; 0 forces all anodes off while the scan keeps running.
- digits_i  in  4*N_DIGITS  hex nibbles; digit k = bits [4k+3:4k]; digit 0 is rightmost.
- dp_i  in  N_DIGITS  decimal point request per digit, active-high.
- blank_i  in  N_DIGITS  per-digit blank request, active-high.
- bright_i  in  BRIGHT_W  brightness level; 0 = dimmest, all-ones = full.
- an  out  N_DIGITS  anode enables, active-low.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame_o  out  1  one-cycle pulse on the first cycle of slot 0.

Behaviour:
- Derived constants:
  - SLOT_CYCLES = CLK_HZ / (REFRESH_HZ*N_DIGITS), integer division.
  - Elaboration error unless SLOT_CYCLES > DEAD_CYCLES and N_DIGITS is in 1..16.
- State:
  - slot counter cnt: 0..SLOT_CYCLES-1
  - digit index idx: 0..N_DIGITS-1
- cnt increments every cycle. At SLOT_CYCLES-1 it wraps to 0 and idx advances. idx wraps from N_DIGITS-1 to 0 (never reaches N_DIGITS).
- Snapshot registers hold digits_i, dp_i, blank_i and bright_i.
  - Loaded on every cycle rst=1.
  - Loaded on the cycle where idx=N_DIGITS-1 and cnt=SLOT_CYCLES-1.
  - Otherwise held. Input changes mid-frame never appear until the next frame.
- Active window length L = ((SLOT_CYCLES-DEAD_CYCLES)*(bright_snap+1)) >> BRIGHT_W, floor. L=0 is permitted and means never lit.
- lit = en && !blank_snap[idx] && cnt >= DEAD_CYCLES && (cnt-DEAD_CYCLES) < L.
  - en is live, not snapshotted.
- Outputs are registered and reflect the state (idx,cnt) of the previous cycle:
  - an = lit ? ~(1<<idx) : all-ones.
  - seg = lit ? hex2seg(digit_snap[idx]) : 7'h7F.
  - dp = lit ? ~dp_snap[idx] : 1.
  - frame_o = 1 exactly when the previous state was idx=0, cnt=0.
- Reset values, and next-cycle values whenever rst=1:
  - cnt=0, idx=0
  - an=all-ones, seg=7'h7F, dp=1, frame_o=0
- Reset mid-frame aborts the scan. The first post-reset cycle starts slot 0 with a freshly loaded snapshot.
- At most one anode is low on any cycle. All anodes are high for at least DEAD_CYCLES cycles between two different digits.
- N_DIGITS=1: idx stays 0; frame_o pulses once per slot.
- hex2seg mapping (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Optional Feature:
- Macro SSD_LZB_EN: leading-zero blanking.
- With the macro defined:
  - Scanning from digit N_DIGITS-1 downward, zero-valued snapshot digits are treated as blanked until the first non-zero digit.
  - Digit 0 is never auto-blanked.
  - dp of an auto-blanked digit is also suppressed.
  - The mask is computed from the snapshot, so it is stable per frame.
- Without the macro, zeros display as '0'. blank_i still applies in both builds.

Decomposition:
- Package ssd_pkg:
  - hex2seg function
  - SEG_OFF constant (7'h7F)
  - typedef seg_t (logic [6:0])
  - typedef nibble_t (logic [3:0])
- Sub-module ssd_slot_timer:
  - Parameters N_DIGITS and SLOT_CYCLES.
  - Owns cnt and idx.
  - Outputs cnt, idx and the end-of-frame strobe.
- Top ssd_scan_driver holds the snapshot, the window compare and the output registers.

Test Plan (N_DIGITS=4, CLK_HZ=4000, REFRESH_HZ=100 -> SLOT_CYCLES=10; DEAD_CYCLES=2, BRIGHT_W=2; so bright=3 gives L=8 and bright=0 gives L=2):
1. Scan order and wrap:
   - Stimulus: rst pulse, digits_i=16'h4321, bright=3, en=1.
   - Per 10-cycle slot: 2 cycles all-ones, then an=1110/1101/1011/0111 for 8 cycles each.
   - seg=79,24,30,19 respectively.
   - frame_o every 40 cycles.
   - an never shows 1111 as an active code and never shows a 5th slot.
2. Brightness:
   - bright=0: each anode low exactly 2 of 10 cycles (cycles 2-3 of its slot).
   - bright=1: each anode low exactly 4 of 10 cycles.
3. Frame coherency:
   - Change digits_i to 16'hFFFF during slot 1.
   - seg keeps 4321 values through slot 3.
   - F (0E) appears in all slots starting with the frame after the next frame_o.
4. Blank/dp/en:
   - blank_i=4'b0100: an[2] stays high through slot 2.
   - dp_i=4'b0010: dp low only in cycles where an=1101.
   - en=0: an stays all-ones within 1 cycle, while frame_o keeps pulsing.
5. Reset mid-operation:
   - Assert rst for 1 cycle during slot 2 active window.
   - Next cycle: an=1111, seg=7F, dp=1.
   - Slot 0 then restarts; first lit cycle is 3 cycles after rst deasserts.
6. SSD_LZB_EN build:
   - digits=16'h0050: digits 3 and 2 dark; digit 1 shows 12; digit 0 shows 40.
   - digits=16'h0000: only an=1110 ever lit, seg=40.
   - Non-LZB build with digits=16'h0050: all four digits lit.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared types and helpers for the seven-segment scan driver.
//   seg_t    : 7-bit cathode vector {g,f,e,d,c,b,a}, active-low
//   nibble_t : one hex digit
//   SEG_OFF  : all segments dark
//   hex2seg  : hex nibble to active-low segment pattern
//   idx_w    : counter width helper (never narrower than 1 bit)
package ssd_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_OFF = 7'h7F;

    function automatic seg_t hex2seg(input nibble_t h);
        seg_t s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Width needed to count 0..n-1; a one-value range still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// ssd_slot_timer -- slot/digit scan counters.
//   clk, rst  : clock, synchronous active-high reset
//   cnt       : cycle position inside the current slot, 0..SLOT_CYCLES-1
//   idx       : digit currently being scanned, 0..N_DIGITS-1
//   frame_end : high on the last cycle of the last slot of a frame
module ssd_slot_timer
    import ssd_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int SLOT_CYCLES = 12500,
    localparam int CW = idx_w(SLOT_CYCLES),
    localparam int IW = idx_w(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic [IW-1:0] idx,
    output logic          frame_end
);

    logic cnt_last;
    logic idx_last;

    assign cnt_last  = (cnt == CW'(SLOT_CYCLES - 1));
    assign idx_last  = (idx == IW'(N_DIGITS - 1));
    assign frame_end = cnt_last && idx_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            // Explicit wrap so non-power-of-two digit counts never reach N_DIGITS.
            idx <= idx_last ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver -- time-multiplexed common-anode seven-segment scan driver.
//   clk, rst  : clock, synchronous active-high reset
//   en        : live display enable (scan keeps running when low)
//   digits_i  : N_DIGITS hex nibbles, digit 0 rightmost
//   dp_i      : per-digit decimal point request, active-high
//   blank_i   : per-digit blank request, active-high
//   bright_i  : brightness, 0 dimmest .. all-ones full
//   an        : anode enables, active-low
//   seg       : cathodes {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point cathode, active-low
//   frame_o   : one-cycle pulse for the first cycle of slot 0
// Optional build macro SSD_LZB_EN enables leading-zero blanking.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int CLK_HZ      = 100_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter int DEAD_CYCLES = 100,
    parameter int BRIGHT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic [BRIGHT_W-1:0]   bright_i,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_o
);

    localparam int SLOT_CYCLES = CLK_HZ / (REFRESH_HZ * N_DIGITS);
    localparam int CW          = idx_w(SLOT_CYCLES);
    localparam int IW          = idx_w(N_DIGITS);
    localparam int ACTIVE      = SLOT_CYCLES - DEAD_CYCLES;

    if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_digits
        $error("ssd_scan_driver: N_DIGITS must be in 1..16");
    end
    if (SLOT_CYCLES <= DEAD_CYCLES) begin : g_bad_slot
        $error("ssd_scan_driver: SLOT_CYCLES must exceed DEAD_CYCLES");
    end

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          frame_end;

    ssd_slot_timer #(
        .N_DIGITS    (N_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .idx       (idx),
        .frame_end (frame_end)
    );

    // Frame-coherent snapshot: refreshed during reset and at the very last
    // cycle of a frame, so a whole frame always shows one consistent value.
    nibble_t               dig_snap [N_DIGITS];
    logic [N_DIGITS-1:0]   dp_snap;
    logic [N_DIGITS-1:0]   blank_snap;
    logic [BRIGHT_W-1:0]   bright_snap;

    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                dig_snap[k] <= digits_i[4*k +: 4];
            end
            dp_snap     <= dp_i;
            blank_snap  <= blank_i;
            bright_snap <= bright_i;
        end
    end

    // Effective blank mask: explicit requests plus, optionally, leading zeros.
    logic [N_DIGITS-1:0] lzb;
    logic [N_DIGITS-1:0] blank_eff;

    always_comb begin
        lzb = '0;
`ifdef SSD_LZB_EN
        begin : lzb_scan
            logic zero_run;
            zero_run = 1'b1;
            // Digit 0 is excluded so an all-zero value still shows a single '0'.
            for (int k = N_DIGITS - 1; k >= 1; k--) begin
                zero_run = zero_run && (dig_snap[k] == 4'h0);
                lzb[k]   = zero_run;
            end
        end
`endif
        blank_eff = blank_snap | lzb;
    end

    // Lit window: starts after the dead time and lasts
    // ((SLOT_CYCLES-DEAD_CYCLES)*(bright+1)) >> BRIGHT_W cycles.
    logic [BRIGHT_W:0] bright_p1;
    logic [63:0]       win_len;
    logic [63:0]       cnt_w;
    logic              lit;

    always_comb begin
        bright_p1 = {1'b0, bright_snap} + {{BRIGHT_W{1'b0}}, 1'b1};
        win_len   = (64'(ACTIVE) * 64'(bright_p1)) >> BRIGHT_W;
        cnt_w     = 64'(cnt);
        lit       = en && !blank_eff[idx]
                    && (cnt_w >= 64'(DEAD_CYCLES))
                    && ((cnt_w - 64'(DEAD_CYCLES)) < win_len);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an      <= '1;
            seg     <= SEG_OFF;
            dp      <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            an      <= lit ? ~(N_DIGITS'(1) << idx) : '1;
            seg     <= lit ? hex2seg(dig_snap[idx]) : SEG_OFF;
            dp      <= lit ? ~dp_snap[idx] : 1'b1;
            frame_o <= (idx == '0) && (cnt == '0);
        end
    end

endmodule
